// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte producers.
// Latency: handshake in cycle N -> uart_start in N+1; sent one cycle after uart_done_tx.
// Backpressure: one-hot req_ready only in IDLE; holds off all requesters until the frame (and gap) ends.
// Optional watchdog on the done pulse: define UART_TX_ARB_TIMEOUT_EN (timeout_err tied 0 otherwise).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_start,
  output logic [7:0]                 uart_data,
  input  logic                       uart_done_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sent,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]   NR_W     = (IDW + 1)'(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t                 state;
  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         ptr_nxt;
  logic [IDW-1:0]         win_id;
  logic                   win_vld;
  logic [7:0]             win_dat;
  logic [2*NUM_REQ-1:0]   vv;
  logic [2*NUM_REQ-1:0]   rot;
  logic [IDW:0]           sum;
  logic                   run_q;
  logic [GW-1:0]          gap_cnt;
  logic                   frame_end;
  logic                   wd_expire;

  // Rotate the valid vector so ptr sits at bit 0, then take the first set bit.
  always_comb begin
    vv      = {req_valid, req_valid};
    rot     = vv >> ptr;
    win_vld = 1'b0;
    win_id  = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && rot[k]) begin
        win_vld = 1'b1;
        sum     = {1'b0, ptr} + (IDW + 1)'(k);
        if (sum >= NR_W) sum = sum - NR_W;
        win_id  = sum[IDW-1:0];
      end
    end
  end

  // Byte mux for the winning requester.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IDW'(i)) win_dat = req_data[i*8 +: 8];
    end
  end

  // run_q keeps req_ready low while reset is held and for the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign req_ready = (state == IDLE && run_q && win_vld) ? (NUM_REQ'(1) << win_id) : '0;
  assign ptr_nxt   = (grant_id == ID_LAST) ? '0 : grant_id + IDW'(1);
  assign frame_end = (state == WAIT_DONE) && (uart_done_tx || wd_expire);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_cnt;

  assign wd_expire = (state == WAIT_DONE) && (wd_cnt == WD_LAST);

  // Watchdog: counts cycles spent in WAIT_DONE; a done in the expiry cycle wins over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_expire && !uart_done_tx;
      if (state != WAIT_DONE)  wd_cnt <= '0;
      else if (!wd_expire)     wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Frame FSM with registered start/busy/sent outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      uart_start <= 1'b0;
      uart_data  <= '0;
      grant_id   <= '0;
      sent       <= 1'b0;
      busy       <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      uart_start <= 1'b0;
      sent       <= 1'b0;
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            uart_data  <= win_dat;
            grant_id   <= win_id;
            uart_start <= 1'b1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (frame_end) begin
            sent <= uart_done_tx;
            ptr  <= ptr_nxt;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
